// File: rtl/inst_fifo_pkg.sv
// inst_fifo_pkg
//   Shared constants and helpers for the instruction-driven single-port FIFO.
//   Bit offsets are measured from DW, so FLUSH sits at inst[DW+2],
//   WE at inst[DW+1] and RE at inst[DW]. Data occupies inst[DW-1:0].
package inst_fifo_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 16;

  localparam int FLUSH_OFS = 2;
  localparam int WE_OFS    = 1;
  localparam int RE_OFS    = 0;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_FLUSH,
    OP_WRITE,
    OP_READ,
    OP_WRITE_READ
  } op_e;

  // FLUSH dominates; WE/RE carried alongside a FLUSH are discarded.
  function automatic op_e decode_op(input logic flush, input logic we, input logic re);
    if (flush)         return OP_FLUSH;
    else if (we && re) return OP_WRITE_READ;
    else if (we)       return OP_WRITE;
    else if (re)       return OP_READ;
    else               return OP_NOP;
  endfunction

endpackage

// File: rtl/inst_sp_fifo_if.sv
// inst_sp_fifo_if
//   Instruction/result bundle of inst_sp_fifo.
//   master : drives inst, inst_valid; observes ready, results and status.
//   slave  : the FIFO side.
//   inst       [DW+2:0] FLUSH | WE | RE | DI
//   inst_ready           instruction accepted when high together with inst_valid
//   res        [DW-1:0]  read data, held between reads
//   read_valid           one-cycle pulse when res is new
//   full, empty, count   occupancy status (count includes a pending write)
//   overflow, underflow  sticky error flags
interface inst_sp_fifo_if
  import inst_fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int AW = $clog2(DEPTH);

  logic [DW+2:0] inst;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] res;
  logic          read_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output inst, inst_valid,
    input  inst_ready, res, read_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  inst, inst_valid,
    output inst_ready, res, read_valid, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/inst_sp_fifo_sp_ram.sv
// sp_ram
//   Single-port synchronous RAM, one access per cycle.
//   en   : access enable
//   we   : 1 = write din to addr, 0 = read addr into dout
//   addr : word address
//   din  : write data
//   dout : read data, valid one cycle after a read; holds otherwise
module sp_ram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // dout only changes on a read so the FIFO can present it as held data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/inst_sp_fifo.sv
// inst_sp_fifo
//   FIFO controlled by a packed instruction word, built on a single-port RAM.
//   A simultaneous write+read on a non-empty FIFO reads now and parks the
//   write data in a one-entry pending register that commits on the next
//   cycle; inst_ready is low for exactly that commit cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : inst_sp_fifo_if slave (instruction in, result and status out)
module inst_sp_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  inst_sp_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic [DW-1:0] byp_q, byp_d;
  logic          res_ram_q, res_ram_d;
  logic          rv_q, rv_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          accept;
  logic [DW-1:0] di;
  op_e           op;
  logic          is_empty;
  logic          is_full;

  assign accept   = bus.inst_valid && !pend_q;
  assign di       = bus.inst[DW-1:0];
  assign op       = accept ? decode_op(bus.inst[DW+FLUSH_OFS],
                                       bus.inst[DW+WE_OFS],
                                       bus.inst[DW+RE_OFS])
                           : OP_NOP;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    byp_d       = byp_q;
    res_ram_d   = res_ram_q;
    rv_d        = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = rptr_q;
    ram_din     = pend_data_q;

    if (pend_q) begin
      // Commit cycle: the RAM port belongs to the parked write, and since
      // inst_ready is low no instruction can compete for it.
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wptr_q;
      ram_din  = pend_data_q;
      wptr_d   = wptr_q + PTR_ONE;
      pend_d   = 1'b0;
    end else begin
      unique case (op)
        OP_FLUSH: begin
          wptr_d  = '0;
          rptr_d  = '0;
          count_d = '0;
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end
        OP_WRITE: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wptr_q;
            ram_din  = di;
            wptr_d   = wptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
          end
        end
        OP_READ: begin
          if (is_empty) begin
            udf_d = 1'b1;
          end else begin
            ram_en    = 1'b1;
            ram_addr  = rptr_q;
            rptr_d    = rptr_q + PTR_ONE;
            count_d   = count_q - CNT_ONE;
            rv_d      = 1'b1;
            res_ram_d = 1'b1;
          end
        end
        OP_WRITE_READ: begin
          if (is_empty) begin
            // Nothing stored: the written word is the oldest, hand it straight back.
            byp_d     = di;
            res_ram_d = 1'b0;
            rv_d      = 1'b1;
          end else begin
            ram_en      = 1'b1;
            ram_addr    = rptr_q;
            rptr_d      = rptr_q + PTR_ONE;
            pend_d      = 1'b1;
            pend_data_d = di;
            rv_d        = 1'b1;
            res_ram_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      byp_q       <= '0;
      res_ram_q   <= 1'b0;
      rv_q        <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      byp_q       <= byp_d;
      res_ram_q   <= res_ram_d;
      rv_q        <= rv_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  sp_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // res comes from whichever source produced the most recent read; the RAM
  // output only moves on reads, so both sources hold between reads.
  assign bus.res        = res_ram_q ? ram_dout : byp_q;
  assign bus.inst_ready = !pend_q;
  assign bus.read_valid = rv_q;
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;

endmodule

// File: tb/tb_inst_sp_fifo.sv
// tb_inst_sp_fifo
//   Directed scenarios plus randomized instruction stream, compared each
//   cycle against a queue-based reference model.
module tb_inst_sp_fifo;
  import inst_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_sp_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  inst_sp_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: stored words in order (a parked write counts as stored).
  logic [DW-1:0] mq[$];
  bit            m_busy;
  logic [DW-1:0] m_res;
  bit            m_rv;
  bit            m_ovf;
  bit            m_udf;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rv"},    64'(bus.read_valid), 64'(m_rv));
    chk({tag, "_res"},   64'(bus.res),        64'(m_res));
    chk({tag, "_cnt"},   64'(bus.count),      64'(mq.size()));
    chk({tag, "_full"},  64'(bus.full),       64'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 64'(bus.empty),      64'(mq.size() == 0));
    chk({tag, "_ovf"},   64'(bus.overflow),   64'(m_ovf));
    chk({tag, "_udf"},   64'(bus.underflow),  64'(m_udf));
    chk({tag, "_rdy"},   64'(bus.inst_ready), 64'(!m_busy));
  endtask

  task automatic step(input bit valid, input bit flush, input bit we, input bit re,
                      input logic [DW-1:0] di, input string tag);
    bit accept;
    bit next_busy;
    bus.inst_valid = valid;
    bus.inst       = {flush, we, re, di};
    accept    = valid && !m_busy;
    next_busy = 1'b0;
    m_rv      = 1'b0;
    if (accept) begin
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else if (we && re) begin
        if (mq.size() == 0) begin
          m_res = di;
        end else begin
          m_res = mq.pop_front();
          mq.push_back(di);
          next_busy = 1'b1;
        end
        m_rv = 1'b1;
      end else if (we) begin
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else                    mq.push_back(di);
      end else if (re) begin
        if (mq.size() == 0) begin
          m_udf = 1'b1;
        end else begin
          m_res = mq.pop_front();
          m_rv  = 1'b1;
        end
      end
    end
    @(posedge clk);
    m_busy = next_busy;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    // A live write is presented during reset to show reset wins.
    rst            = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst       = {1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    bus.inst_valid = 1'b0;
    mq.delete();
    m_busy = 1'b0;
    m_res  = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    rst            = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // In-order reads with latency 1
    step(1, 0, 1, 0, 32'hA, "s30_w");
    step(1, 0, 1, 0, 32'hB, "s30_w");
    step(1, 0, 1, 0, 32'hC, "s30_w");
    step(1, 0, 0, 1, 32'h0, "s30_r0");
    chk("s30_res0", 64'(bus.res), 64'hA);
    step(1, 0, 0, 1, 32'h0, "s30_r1");
    chk("s30_res1", 64'(bus.res), 64'hB);
    step(1, 0, 0, 1, 32'h0, "s30_r2");
    chk("s30_res2", 64'(bus.res), 64'hC);
    step(0, 0, 0, 0, 32'h0, "s30_idle");
    chk("s30_empty", 64'(bus.empty), 64'h1);

    // Overfill
    do_reset("rst1");
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, 32'(i), "s31_w");
    chk("s31_full", 64'(bus.full), 64'h1);
    chk("s31_ovf",  64'(bus.overflow), 64'h1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 1, 32'h0, "s31_r");
      chk("s31_rdata", 64'(bus.res), 64'(i));
    end

    // Write+read with parked write; a read offered during the commit is ignored
    do_reset("rst2");
    step(1, 0, 1, 0, 32'h1, "s32_w");
    step(1, 0, 1, 0, 32'h2, "s32_w");
    step(1, 0, 1, 1, 32'h9, "s32_wr");
    chk("s32_res", 64'(bus.res), 64'h1);
    chk("s32_rdy", 64'(bus.inst_ready), 64'h0);
    step(1, 0, 0, 1, 32'h0, "s32_commit");
    step(1, 0, 0, 1, 32'h0, "s32_r");
    chk("s32_rd2", 64'(bus.res), 64'h2);
    step(1, 0, 0, 1, 32'h0, "s32_r");
    chk("s32_rd9", 64'(bus.res), 64'h9);

    // Bypass on empty
    do_reset("rst3");
    step(1, 0, 1, 1, 32'h7, "s33_byp");
    chk("s33_res", 64'(bus.res), 64'h7);
    chk("s33_cnt", 64'(bus.count), 64'h0);

    // Underflow then flush
    do_reset("rst4");
    step(1, 0, 0, 1, 32'h0, "s34_r");
    chk("s34_udf", 64'(bus.underflow), 64'h1);
    step(1, 1, 1, 1, 32'h55, "s34_fl");
    chk("s34_udf_clr", 64'(bus.underflow), 64'h0);

    // Reset during a pending commit
    do_reset("rst5");
    step(1, 0, 1, 0, 32'h1, "s35_w");
    step(1, 0, 1, 0, 32'h2, "s35_w");
    step(1, 0, 1, 1, 32'h5, "s35_wr");
    do_reset("s35_rst");
    step(1, 0, 0, 1, 32'h0, "s35_r");
    chk("s35_udf", 64'(bus.underflow), 64'h1);

    // Random stream
    do_reset("rst6");
    for (int i = 0; i < 500; i++) begin
      bit v, f, w, r;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      w = $urandom_range(0, 1);
      r = $urandom_range(0, 1);
      step(v, f, w, r, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_sp_fifo.md
INST_SP_FIFO -- requirements
Module: inst_sp_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count (power of two, >=2); AW = clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port inst, input, DW+3, meaning instruction: [DW+2] FLUSH, [DW+1] WE, [DW] RE, [DW-1:0] DI.
REQ-006 SHALL have port inst_valid, input, 1, meaning inst is presented this cycle.
REQ-007 SHALL have port inst_ready, output, 1, meaning inst is accepted this cycle if inst_valid is also high.
REQ-008 SHALL have port res, output, DW, meaning read data; holds its last value between reads.
REQ-009 SHALL have port read_valid, output, 1, meaning a one-cycle pulse marking res as new.
REQ-010 SHALL have ports full, empty, output, 1 each, meaning occupancy status.
REQ-011 SHALL have port count, output, AW+1, meaning occupancy, 0..DEPTH, including any pending write.
REQ-012 SHALL have ports overflow, underflow, output, 1 each, meaning sticky error flags.

Function
REQ-013 SHALL treat an instruction as accepted only when inst_valid && inst_ready are high on the same edge; non-accepted inst is ignored.
REQ-014 SHALL perform at most one storage access per cycle (read or write, single-port RAM).
REQ-015 SHALL issue a read for accepted RE with count>0; res updates and read_valid pulses at the next edge (latency 1); order is FIFO.
REQ-016 SHALL write DI for accepted WE (without RE) with count<DEPTH in the same cycle; count increments by 1.
REQ-017 SHALL, for accepted WE&RE with count>0 and RAM non-empty, perform the read and place DI in a 1-entry pending register; count unchanged.
REQ-018 SHALL commit the pending register to RAM on the following cycle; inst_ready SHALL be 0 exactly while the pending register is occupied.
REQ-019 SHALL, for accepted WE&RE with count==0, forward DI to res with read_valid at the next edge (bypass), leaving RAM and count unchanged.
REQ-020 SHALL drop accepted WE (without RE) when full, set overflow, and leave state otherwise unchanged.
REQ-021 SHALL ignore accepted RE when empty (no WE), set underflow, and produce no read_valid.
REQ-022 SHALL, for accepted FLUSH, clear pointers, count, pending entry, overflow and underflow at the next edge; WE/RE in the same inst are ignored; res holds its value.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; full = (count==DEPTH), empty = (count==0), both combinational from count.
REQ-024 SHALL keep overflow/underflow set until FLUSH or rst.

Reset
REQ-025 SHALL, at rst high on an edge, set pointers=0, count=0, pending cleared, res=0, read_valid=0, overflow=0, underflow=0; inst_ready=1 after reset.
REQ-026 SHALL have rst override any concurrent instruction, including a pending commit; RAM contents need not be cleared.

Structure
REQ-027 SHALL place bit-position constants for FLUSH/WE/RE and the default DW/DEPTH in shared package inst_fifo_pkg.
REQ-028 SHALL instantiate one sub-module sp_ram (single-port synchronous RAM: en, we, addr, din, dout; 1-cycle read latency).
REQ-029 SHALL keep pointer, count, pending and flag logic in inst_sp_fifo itself.

Verification (DW=32, DEPTH=4)
REQ-030 SHALL cover: write 0xA,0xB,0xC then 3 reads -> res 0xA,0xB,0xC each one cycle after its read, read_valid 3 single pulses, empty=1.
REQ-031 SHALL cover: 5 writes 1..5 -> count=4, full=1, overflow=1, reads return 1..4.
REQ-032 SHALL cover: count=2 {1,2}, WE&RE DI=9 -> res=1, inst_ready=0 next cycle, count=2, then reads 2,9.
REQ-033 SHALL cover: empty, WE&RE DI=7 -> res=7, read_valid pulse, count=0, underflow=0.
REQ-034 SHALL cover: read when empty -> underflow=1, no read_valid; then FLUSH -> underflow=0, count=0.
REQ-035 SHALL cover: rst asserted during a pending commit -> count=0, inst_ready=1, subsequent read -> underflow=1.
